// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Purpose  : Round-robin, burst-aware arbiter sharing one FIFO push port among
//            N_REQ valid/ready producers. A producer that starts a non-last
//            beat keeps the FIFO until its 'last' beat or MAX_BURST beats.
// Option   : FIFO_ARB_STATS_EN adds per-requester 32-bit accepted-beat
//            counters on push_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0]            req_last_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_push_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]         push_count_o
`endif
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    rr_ptr;
  logic [BEAT_W-1:0]   beats;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;
  logic                sel_last;
  logic                xfer;
  logic                burst_done;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin : p_winner
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_found && req_valid_i[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // Selected requester: the round-robin winner when idle, the owner when locked.
  // Reset masks the selection so every output reads zero during reset.
  always_comb begin : p_select
    if (state == IDLE) begin
      sel_found = win_found;
      sel_idx   = win_idx;
    end else begin
      sel_found = 1'b1;
      sel_idx   = owner;
    end
    if (rst_i) sel_found = 1'b0;
    sel_valid  = req_valid_i[sel_idx];
    sel_last   = req_last_i[sel_idx];
    xfer       = sel_found && sel_valid && !fifo_full_i;
    burst_done = sel_last || (beats == BEAT_W'(MAX_BURST - 1));
  end

  // Output steering: one-hot grant/ready and the selected data slice.
  always_comb begin : p_outputs
    grant_o     = '0;
    req_ready_o = '0;
    fifo_data_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_found && (sel_idx == IDX_W'(i))) begin
        grant_o[i]     = 1'b1;
        req_ready_o[i] = !fifo_full_i;
        fifo_data_o    = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    fifo_push_o = xfer;
  end

  assign busy_o = (state == BURST) && !rst_i;

  // Arbitration state machine: lock on a non-last beat, rotate on release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      beats  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (!sel_last && (MAX_BURST > 1)) begin
              state <= BURST;
              owner <= sel_idx;
              beats <= BEAT_W'(1);
            end else begin
              rr_ptr <= (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
            end
          end
        end
        BURST: begin
          if (xfer) begin
            if (burst_done) begin
              state  <= IDLE;
              rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
              beats  <= '0;
            end else begin
              beats <= beats + BEAT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
      logic [31:0] count;
      // Accepted-beat counter for requester g; wraps naturally at 2^32.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          count <= '0;
        end else if (xfer && (sel_idx == IDX_W'(g))) begin
          count <= count + 32'd1;
        end
      end
      assign push_count_o[g*32 +: 32] = count;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Purpose  : Directed self-checking bench for fifo_push_arbiter
//            (N_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_push;
  logic [DW-1:0]   fifo_data;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*32-1:0] push_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  fifo_push_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_last_i   (req_last),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_full_i  (fifo_full),
    .fifo_push_o  (fifo_push),
    .fifo_data_o  (fifo_data),
    .grant_o      (grant),
    .busy_o       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .push_count_o (push_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] data_of(input int idx);
    return 32'hC0DE_0000 + 32'(idx) * 32'h111;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, check combinational/registered outputs at the
  // falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] l,
                      input logic f, input logic r, input logic [3:0] eg,
                      input logic ep, input logic [3:0] er, input logic [3:0] rmask,
                      input logic eb);
    int gi;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    rst       = r;
    @(negedge clk);
    check({tag, " grant"}, 64'(grant), 64'(eg));
    check({tag, " push"},  64'(fifo_push), 64'(ep));
    check({tag, " ready"}, 64'(req_ready & rmask), 64'(er & rmask));
    check({tag, " busy"},  64'(busy), 64'(eb));
    if (ep) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (eg[i]) gi = i;
      check({tag, " data"}, 64'(fifo_data), 64'(data_of(gi)));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = data_of(i);
    rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
    @(posedge clk); #1;

    // Reset: everything quiet even with all requesters valid.
    step("rst0", 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'hF, 1'b0);
`ifdef FIFO_ARB_STATS_EN
    check("stats rst", 64'(push_count[127:0] != '0), 64'd0);
`endif

    // Round robin with single-beat requests: 0,1,2,3,0,1 -> rr_ptr ends at 2.
    for (int c = 0; c < 6; c++) begin
      step($sformatf("rr%0d", c), 4'b1111, 4'b1111, 1'b0, 1'b0,
           4'(1 << (c % 4)), 1'b1, 4'(1 << (c % 4)), 4'hF, 1'b0);
    end

    // Burst cap: req2 non-last, req0 single beats. Four from 2, one from 0,
    // then 2 locks again for two beats (beats=2 afterwards).
    step("bc_a", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b0);
    step("bc_b", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);
    step("bc_c", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);
    step("bc_d", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);
    step("bc_e", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hF, 1'b0);
    step("bc_f", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b0);
    step("bc_g", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);

    // Full stall at beats=2: nothing moves, lock holds, then two more beats
    // reach the cap (which proves beats did not advance while full).
    for (int c = 0; c < 3; c++) begin
      step($sformatf("full%0d", c), 4'b0101, 4'b0001, 1'b1, 1'b0,
           4'b0100, 1'b0, 4'b0000, 4'hF, 1'b1);
    end
    step("res_a", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);
    step("res_b", 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);

    // Owner gap: rr_ptr=3, req3 locks, drops valid for two cycles while req1
    // waits; req1 must never see ready. Burst ends on req3's last.
    step("gap_a", 4'b1010, 4'b0010, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'hF, 1'b0);
    step("gap_b", 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0111, 1'b1);
    step("gap_c", 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0111, 1'b1);
    step("gap_d", 4'b1010, 4'b1010, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'hF, 1'b1);
    step("gap_e", 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'hF, 1'b0);

    // Reset mid-burst: req2 locks (rr_ptr=2), reach beats=3, then reset.
    step("mr_a", 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b0);
    step("mr_b", 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);
    step("mr_c", 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'hF, 1'b1);
    step("mr_r", 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'hF, 1'b0);
    step("mr_d", 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'hF, 1'b0);

`ifdef FIFO_ARB_STATS_EN
    // Stats: clear, then 10 beats from req1 and 3 from req3.
    step("st_r", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'hF, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step($sformatf("st1_%0d", c), 4'b0010, 4'b0010, 1'b0, 1'b0,
           4'b0010, 1'b1, 4'b0010, 4'hF, 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      step($sformatf("st3_%0d", c), 4'b1000, 4'b1000, 1'b0, 1'b0,
           4'b1000, 1'b1, 4'b1000, 4'hF, 1'b0);
    end
    check("stats r0", 64'(push_count[0*32 +: 32]), 64'd0);
    check("stats r1", 64'(push_count[1*32 +: 32]), 64'd10);
    check("stats r2", 64'(push_count[2*32 +: 32]), 64'd0);
    check("stats r3", 64'(push_count[3*32 +: 32]), 64'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
